mmcm_drp_reconfig: RTL and testbench
====================================

Name: mmcm_drp_reconfig

Overview:
Runtime reconfiguration controller for an MMCME2_ADV through its DRP port. It accepts a stream of (address, keep-mask, data) register entries and holds the MMCM in reset while it applies them. Each entry is a read-modify-write. After the last entry it releases reset and waits for lock. It sits beside an MMCM clock wrapper and lets pixel/serial clock ratios change without a new bitstream. It runs on a free-running clock that is not derived from the MMCM.

Parameters:
RST_HOLD, 8, cycles o_mmcm_rst is held high before the first DRP access
DRDY_TIMEOUT, 64, max cycles to wait for i_drp_drdy per access
LOCK_TIMEOUT, 65536, max cycles to wait for synchronised lock after reset release

Ports:
i_clk  in  1  DRP/control clock; free-running, not sourced from the MMCM
i_rst_n  in  1  asynchronous active-low reset
i_cfg_valid  in  1  entry valid
o_cfg_ready  out  1  entry accept; a transfer happens on valid&&ready
i_cfg_addr  in  7  DRP register address
i_cfg_mask  in  16  bits to keep from the current register value (1 = keep)
i_cfg_data  in  16  new bits; only bits where mask=0 are used
i_cfg_last  in  1  marks the final entry of a sequence
o_busy  out  1  high from sequence start until the return to IDLE
o_done  out  1  one-cycle pulse: sequence applied and MMCM locked
o_error  out  1  one-cycle pulse: sequence aborted or lock failed
o_err_code  out  2  0 none, 1 DRDY timeout, 2 lock timeout; held until the next sequence starts
o_drp_den  out  1  DRP enable, one-cycle pulse
o_drp_dwe  out  1  DRP write enable, asserted together with o_drp_den on writes only
o_drp_daddr  out  7  DRP address
o_drp_di  out  16  DRP write data
i_drp_do  in  16  DRP read data, valid when i_drp_drdy=1
i_drp_drdy  in  1  DRP access complete
o_mmcm_rst  out  1  MMCM RST
i_mmcm_locked  in  1  MMCM LOCKED (asynchronous to i_clk)
o_locked  out  1  i_mmcm_locked after a 2-flop synchroniser

Behaviour:
- Reset (i_rst_n low, async):
  - State goes to IDLE.
  - All outputs are 0, including o_mmcm_rst and o_err_code.
  - The synchroniser flops are cleared.
- FSM states: IDLE, HOLD, FETCH, RD, RD_WAIT, WR, WR_WAIT, LOCK_WAIT, DRAIN.
- IDLE:
  - o_cfg_ready=0.
  - i_cfg_valid=1 -> HOLD. o_mmcm_rst goes 1, o_busy goes 1, o_err_code clears to 0.
  - The entry is not consumed in IDLE.
- HOLD: counts RST_HOLD cycles, then -> FETCH.
- FETCH:
  - o_cfg_ready=1.
  - On a transfer, register addr, mask, data and last, then -> RD.
  - Ready is low in every state except FETCH and DRAIN.
- RD: o_drp_den=1, o_drp_dwe=0, o_drp_daddr=addr for exactly one cycle, then -> RD_WAIT.
- RD_WAIT:
  - On i_drp_drdy, capture new = (i_drp_do & mask) | (data & ~mask), then -> WR.
  - If DRDY_TIMEOUT cycles elapse without drdy, set err_code=1 and go -> DRAIN.
- WR: o_drp_den=1, o_drp_dwe=1, o_drp_di=new for one cycle, then -> WR_WAIT.
- WR_WAIT:
  - On drdy: if last -> LOCK_WAIT, deasserting o_mmcm_rst on the same edge; otherwise -> FETCH.
  - Timeout behaves as in RD_WAIT.
- DRAIN (DRP abort):
  - o_mmcm_rst stays 1 and o_cfg_ready=1.
  - Remaining entries are discarded until one is accepted with last=1.
  - If the aborted entry itself had last=1, skip draining.
  - Then o_mmcm_rst=0, pulse o_error, -> IDLE.
- LOCK_WAIT:
  - On o_locked=1, pulse o_done, o_busy=0, -> IDLE.
  - If LOCK_TIMEOUT cycles elapse, set err_code=2, pulse o_error, -> IDLE. o_mmcm_rst stays 0.
- Timeout counters:
  - Each counter reloads on entry to its wait state.
  - Width is $clog2(param+1).
  - Timeout fires on the cycle the count reaches the parameter value.
- DRP protocol rules:
  - Never issue den while an access is outstanding.
  - A drdy received outside RD_WAIT/WR_WAIT is ignored.
- o_done and o_error never assert in the same cycle. Neither asserts outside the final transition.
- i_cfg_valid arriving during LOCK_WAIT is not accepted. It starts a new sequence after the return to IDLE.
- o_locked tracks the synchroniser in all states, 2-cycle latency.
- Async reset mid-sequence:
  - Immediately drops o_mmcm_rst and den/dwe.
  - No done/error pulse.
  - A partially written MMCM is the host's responsibility.

Test Plan:
- Single entry addr=0x08, mask=0x1000, data=0x0104, DRP model returns 0x1FFF, lock after 20 cycles:
  - one read then one write to 0x08 with di=0x1104.
  - o_mmcm_rst high from start to the edge after write drdy.
  - o_done pulse exactly 2 cycles after i_mmcm_locked rises.
  - err_code=0.
- Three entries (0x08, 0x09, 0x16), last on the third:
  - exactly 3 read/write pairs in order.
  - ready only in FETCH; RST_HOLD=8 cycles before the first den.
  - no den overlaps an outstanding access.
- DRP model never asserts drdy on the second entry's read, 5-entry sequence:
  - timeout after 64 cycles.
  - remaining 3 entries are drained.
  - o_error pulse, err_code=1, o_mmcm_rst=0 after the last entry is accepted.
  - no write issued to the second address.
- LOCK_TIMEOUT=100, i_mmcm_locked held 0:
  - o_error pulses 100 cycles after reset release.
  - err_code=2, o_busy falls the same cycle.
  - the next sequence start clears err_code to 0.
- Assert i_rst_n low during WR_WAIT of entry 2:
  - all outputs are 0 asynchronously, no done/error pulse.
  - after release a new single-entry sequence completes normally.
- Spurious i_drp_drdy pulses in IDLE and FETCH, valid held during LOCK_WAIT:
  - no state change and no extra DRP access.
  - the held entry is consumed only by the next sequence.

Source files
------------

// File: rtl/mmcm_drp_reconfig.sv
// MMCME2_ADV runtime reconfiguration: applies read-modify-write DRP entries
// while holding the MMCM in reset, then releases it and waits for lock.
module mmcm_drp_reconfig #(
    parameter int RST_HOLD     = 8,
    parameter int DRDY_TIMEOUT = 64,
    parameter int LOCK_TIMEOUT = 65536
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_cfg_valid,
    output logic        o_cfg_ready,
    input  logic [6:0]  i_cfg_addr,
    input  logic [15:0] i_cfg_mask,
    input  logic [15:0] i_cfg_data,
    input  logic        i_cfg_last,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error,
    output logic [1:0]  o_err_code,
    output logic        o_drp_den,
    output logic        o_drp_dwe,
    output logic [6:0]  o_drp_daddr,
    output logic [15:0] o_drp_di,
    input  logic [15:0] i_drp_do,
    input  logic        i_drp_drdy,
    output logic        o_mmcm_rst,
    input  logic        i_mmcm_locked,
    output logic        o_locked
);

    localparam int HW = $clog2(RST_HOLD + 1);
    localparam int DW = $clog2(DRDY_TIMEOUT + 1);
    localparam int LW = $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_HOLD, S_FETCH, S_RD, S_RD_WAIT, S_WR, S_WR_WAIT, S_LOCK_WAIT, S_DRAIN
    } state_t;

    state_t        r_state, w_next;
    logic [HW-1:0] r_hold_cnt;
    logic [DW-1:0] r_drdy_cnt;
    logic [LW-1:0] r_lock_cnt;
    logic [6:0]    r_addr;
    logic [15:0]   r_mask, r_data, r_new;
    logic          r_last, r_mmcm_rst, r_sync1, r_sync2;
    logic [1:0]    r_err_code;
    logic          w_ready, w_den, w_dwe, w_done, w_error, w_xfer;
    logic          w_drdy_to, w_lock_to;

    assign w_xfer    = w_ready & i_cfg_valid;
    assign w_drdy_to = (r_drdy_cnt == DW'(DRDY_TIMEOUT));
    assign w_lock_to = (r_lock_cnt == LW'(LOCK_TIMEOUT));

    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        w_den   = 1'b0;
        w_dwe   = 1'b0;
        w_done  = 1'b0;
        w_error = 1'b0;
        case (r_state)
            S_IDLE:    if (i_cfg_valid) w_next = S_HOLD;
            S_HOLD:    if (r_hold_cnt == HW'(RST_HOLD - 1)) w_next = S_FETCH;
            S_FETCH: begin
                w_ready = 1'b1;
                if (i_cfg_valid) w_next = S_RD;
            end
            S_RD: begin
                w_den  = 1'b1;
                w_next = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (i_drp_drdy)     w_next = S_WR;
                else if (w_drdy_to) w_next = S_DRAIN;
            end
            S_WR: begin
                w_den  = 1'b1;
                w_dwe  = 1'b1;
                w_next = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                if (i_drp_drdy)     w_next = r_last ? S_LOCK_WAIT : S_FETCH;
                else if (w_drdy_to) w_next = S_DRAIN;
            end
            S_LOCK_WAIT: begin
                if (r_sync2) begin
                    w_done = 1'b1;
                    w_next = S_IDLE;
                end else if (w_lock_to) begin
                    w_error = 1'b1;
                    w_next  = S_IDLE;
                end
            end
            S_DRAIN: begin
                // An aborted final entry leaves nothing to drain, so accept nothing.
                w_ready = ~r_last;
                if (r_last || (i_cfg_valid && i_cfg_last)) begin
                    w_error = 1'b1;
                    w_next  = S_IDLE;
                end
            end
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_hold_cnt <= '0;
            r_drdy_cnt <= '0;
            r_lock_cnt <= '0;
            r_addr     <= '0;
            r_last     <= 1'b0;
            r_new      <= '0;
            r_mmcm_rst <= 1'b0;
            r_err_code <= 2'd0;
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_sync1 <= i_mmcm_locked;
            r_sync2 <= r_sync1;
            // Counters hold zero outside their state, so each wait starts fresh.
            r_hold_cnt <= (r_state == S_HOLD) ? r_hold_cnt + HW'(1) : '0;
            r_drdy_cnt <= (r_state == S_RD_WAIT || r_state == S_WR_WAIT) ?
                          r_drdy_cnt + DW'(1) : '0;
            r_lock_cnt <= (r_state == S_LOCK_WAIT) ? r_lock_cnt + LW'(1) : '0;
            if (r_state == S_FETCH && w_xfer) begin
                r_addr <= i_cfg_addr;
                r_last <= i_cfg_last;
            end
            if (r_state == S_RD_WAIT && i_drp_drdy)
                r_new <= (i_drp_do & r_mask) | (r_data & ~r_mask);
            case (r_state)
                S_IDLE: if (i_cfg_valid) begin
                    r_mmcm_rst <= 1'b1;
                    r_err_code <= 2'd0;
                end
                S_RD_WAIT:   if (!i_drp_drdy && w_drdy_to) r_err_code <= 2'd1;
                S_WR_WAIT: begin
                    if (i_drp_drdy && r_last)       r_mmcm_rst <= 1'b0;
                    else if (!i_drp_drdy && w_drdy_to) r_err_code <= 2'd1;
                end
                S_LOCK_WAIT: if (!r_sync2 && w_lock_to) r_err_code <= 2'd2;
                S_DRAIN:     if (w_error) r_mmcm_rst <= 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (r_state == S_FETCH && w_xfer) begin
            r_mask <= i_cfg_mask;
            r_data <= i_cfg_data;
        end
    end

    assign o_cfg_ready = w_ready;
    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = w_done;
    assign o_error     = w_error;
    assign o_err_code  = r_err_code;
    assign o_drp_den   = w_den;
    assign o_drp_dwe   = w_dwe;
    assign o_drp_daddr = r_addr;
    assign o_drp_di    = r_new;
    assign o_mmcm_rst  = r_mmcm_rst;
    assign o_locked    = r_sync2;

endmodule

// File: tb/tb_mmcm_drp_reconfig.sv
// Scoreboard bench for mmcm_drp_reconfig with a DRP slave and MMCM lock model.
module tb_mmcm_drp_reconfig;

    localparam int RST_HOLD     = 8;
    localparam int DRDY_TIMEOUT = 64;
    localparam int LOCK_TIMEOUT = 100;
    localparam int DRP_LAT      = 3;
    localparam int LOCK_DELAY   = 20;

    logic        clk, rst_n;
    logic        cfg_valid, cfg_ready, cfg_last;
    logic [6:0]  cfg_addr, daddr;
    logic [15:0] cfg_mask, cfg_data, di, drp_do;
    logic        busy, done, error, den, dwe, drdy, mmcm_rst, locked_in, locked_out;
    logic [1:0]  err_code;

    mmcm_drp_reconfig #(
        .RST_HOLD(RST_HOLD), .DRDY_TIMEOUT(DRDY_TIMEOUT), .LOCK_TIMEOUT(LOCK_TIMEOUT)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cfg_valid(cfg_valid), .o_cfg_ready(cfg_ready),
        .i_cfg_addr(cfg_addr), .i_cfg_mask(cfg_mask), .i_cfg_data(cfg_data),
        .i_cfg_last(cfg_last),
        .o_busy(busy), .o_done(done), .o_error(error), .o_err_code(err_code),
        .o_drp_den(den), .o_drp_dwe(dwe), .o_drp_daddr(daddr), .o_drp_di(di),
        .i_drp_do(drp_do), .i_drp_drdy(drdy),
        .o_mmcm_rst(mmcm_rst), .i_mmcm_locked(locked_in), .o_locked(locked_out)
    );

    typedef struct { bit we; logic [6:0] addr; logic [15:0] data; } acc_t;
    typedef struct { bit is_err; logic [1:0] code; } res_t;

    acc_t        acc_q[$];
    res_t        res_q[$];
    logic [15:0] mem [128];

    int checks = 0, errors = 0;
    int cyc = 0;
    int wr_cnt = 0, den_cnt = 0;
    int kill_addr = -1, kill_den_cyc = 0;
    int rst_rise_cyc = 0, rst_fall_cyc = 0, lock_rise_cyc = 0, last_wr_drdy_cyc = 0;
    bit lock_en = 1'b1, spur_req = 1'b0, post = 1'b0;
    logic [1:0]  post_code = 2'd0;
    logic [15:0] last_di = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor, DRP slave and lock model, all evaluated away from the active edge.
    initial begin : monitor
        int   pend;
        bit   outstanding, first_den, prev_rst, drain_fall;
        logic [1:0]  prev_ec;
        logic [6:0]  pa;
        logic [15:0] pdi;
        bit   pwe;
        int   lcnt;
        acc_t a;
        res_t r;
        pend = 0; outstanding = 0; first_den = 0; prev_rst = 0; prev_ec = 0;
        pa = 0; pdi = 0; pwe = 0; lcnt = 0;
        drdy = 1'b0; drp_do = '0; locked_in = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend = 0; outstanding = 0; first_den = 0; post = 0;
                prev_rst = 0; prev_ec = 0; drdy = 1'b0;
                continue;
            end
            drain_fall = post && (post_code == 2'd1);
            if (post) begin
                chk("busy_after_pulse", 32'(busy), 32'd0);
                chk("err_code_after_pulse", 32'(err_code), 32'(post_code));
                chk("mmcm_rst_after_pulse", 32'(mmcm_rst), 32'd0);
                post = 0;
            end
            if (done || error) begin
                chk("done_error_exclusive", 32'(done & error), 32'd0);
                if (res_q.size() == 0) chk("unexpected_pulse", 32'({done, error}), 32'd0);
                else begin
                    r = res_q.pop_front();
                    chk("pulse_kind", 32'(error), 32'(r.is_err));
                    if (done) chk("done_latency", 32'(cyc - lock_rise_cyc), 32'd2);
                    if (r.code == 2'd2) chk("lock_timeout_latency", 32'(cyc - rst_fall_cyc), 32'(LOCK_TIMEOUT));
                    post = 1; post_code = r.code;
                end
            end
            if (mmcm_rst && !prev_rst) begin
                rst_rise_cyc = cyc; first_den = 1;
                chk("err_code_cleared_at_start", 32'(err_code), 32'd0);
            end
            if (!mmcm_rst && prev_rst) begin
                rst_fall_cyc = cyc;
                if (!drain_fall && res_q.size() > 0)
                    chk("rst_release_after_wr_drdy", 32'(cyc - last_wr_drdy_cyc), 32'd1);
            end
            prev_rst = mmcm_rst;
            if (busy && !mmcm_rst) chk("ready_in_lock_wait", 32'(cfg_ready), 32'd0);
            if (err_code == 2'd1 && prev_ec != 2'd1)
                chk("drdy_timeout_latency", 32'(cyc - kill_den_cyc), 32'(DRDY_TIMEOUT + 2));
            prev_ec = err_code;
            // DRP slave response for an earlier access
            drdy = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    drdy = 1'b1; drp_do = mem[pa]; outstanding = 0;
                    if (pwe) begin mem[pa] = pdi; last_wr_drdy_cyc = cyc; end
                end
            end else if (spur_req) begin
                drdy = 1'b1; drp_do = 16'hDEAD; spur_req = 1'b0;
            end
            if (den) begin
                den_cnt++;
                chk("den_overlap", 32'(outstanding), 32'd0);
                chk("ready_at_den", 32'(cfg_ready), 32'd0);
                if (first_den) begin
                    chk("hold_before_first_den", 32'(cyc - rst_rise_cyc), 32'(RST_HOLD + 1));
                    first_den = 0;
                end
                if (acc_q.size() == 0) chk("unexpected_den", 32'(den), 32'd0);
                else begin
                    a = acc_q.pop_front();
                    chk("acc_we", 32'(dwe), 32'(a.we));
                    chk("acc_addr", 32'(daddr), 32'(a.addr));
                    if (a.we) chk("acc_di", 32'(di), 32'(a.data));
                end
                if (dwe) begin wr_cnt++; last_di = di; end
                if (!dwe && int'(daddr) == kill_addr) kill_den_cyc = cyc;
                else begin
                    pend = DRP_LAT; outstanding = 1; pa = daddr; pwe = dwe; pdi = di;
                end
            end
            if (mmcm_rst) begin locked_in = 1'b0; lcnt = 0; end
            else if (lock_en && !locked_in) begin
                lcnt++;
                if (lcnt == LOCK_DELAY) begin locked_in = 1'b1; lock_rise_cyc = cyc; end
            end
        end
    end

    task automatic send_entry(input logic [6:0] a, input logic [15:0] m, input logic [15:0] d,
                              input bit last, input bit prd, input bit pwr,
                              input bit pres, input bit rerr, input logic [1:0] rcode);
        acc_t x;
        res_t r;
        int   t;
        if (prd) begin x.we = 0; x.addr = a; x.data = '0; acc_q.push_back(x); end
        if (pwr) begin x.we = 1; x.addr = a; x.data = (mem[a] & m) | (d & ~m); acc_q.push_back(x); end
        if (pres) begin r.is_err = rerr; r.code = rcode; res_q.push_back(r); end
        cfg_valid = 1'b1; cfg_addr = a; cfg_mask = m; cfg_data = d; cfg_last = last;
        t = 0;
        while (t < 1000) begin
            @(negedge clk);
            if (cfg_ready) break;
            t++;
        end
        if (t >= 1000) begin chk("send_timeout", 32'(t), 32'd0); cfg_valid = 1'b0; end
        @(posedge clk); #1;
    endtask

    task automatic wait_idle(input int bound);
        int t;
        t = 0;
        while ((busy || res_q.size() != 0 || post) && t < bound) begin
            @(negedge clk);
            t++;
        end
        if (t >= bound) chk("wait_idle_timeout", 32'(t), 32'd0);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mmcm_rst"}, 32'(mmcm_rst), 32'd0);
        chk({tag, "_busy_ready"}, 32'({busy, cfg_ready}), 32'd0);
        chk({tag, "_den_dwe"}, 32'({den, dwe}), 32'd0);
        chk({tag, "_done_error"}, 32'({done, error}), 32'd0);
        chk({tag, "_err_code"}, 32'(err_code), 32'd0);
        chk({tag, "_locked"}, 32'(locked_out), 32'd0);
        chk({tag, "_drp_bus"}, 32'({daddr, di}), 32'd0);
    endtask

    initial begin : main
        int base, base_den, t;
        for (int i = 0; i < 128; i++) mem[i] = 16'(i * 16'h0731) ^ 16'h5A5A;
        mem[8] = 16'h1FFF;
        rst_n = 1'b0; cfg_valid = 1'b0; cfg_addr = '0; cfg_mask = '0; cfg_data = '0; cfg_last = 1'b0;
        #12;
        chk_all_zero("reset");
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;

        // Single entry
        send_entry(7'h08, 16'h1000, 16'h0104, 1, 1, 1, 1, 0, 2'd0);
        cfg_valid = 1'b0;
        wait_idle(1000);
        chk("t1_write_data", 32'(last_di), 32'h1104);

        // Three entries
        base = wr_cnt;
        send_entry(7'h08, 16'h00FF, 16'hAB00, 0, 1, 1, 0, 0, 2'd0);
        send_entry(7'h09, 16'hF0F0, 16'h1234, 0, 1, 1, 0, 0, 2'd0);
        send_entry(7'h16, 16'h0000, 16'hBEEF, 1, 1, 1, 1, 0, 2'd0);
        cfg_valid = 1'b0;
        wait_idle(1000);
        chk("t2_write_count", 32'(wr_cnt - base), 32'd3);

        // Read of second entry never completes; remaining entries drain
        kill_addr = 'h0A;
        send_entry(7'h20, 16'hFF00, 16'h00AA, 0, 1, 1, 0, 0, 2'd0);
        send_entry(7'h0A, 16'h0F0F, 16'h5555, 0, 1, 0, 0, 0, 2'd0);
        send_entry(7'h21, 16'h0000, 16'h1111, 0, 0, 0, 0, 0, 2'd0);
        send_entry(7'h22, 16'h0000, 16'h2222, 0, 0, 0, 0, 0, 2'd0);
        send_entry(7'h23, 16'h0000, 16'h3333, 1, 0, 0, 1, 1, 2'd1);
        cfg_valid = 1'b0;
        wait_idle(1000);
        kill_addr = -1;

        // Lock never arrives, then a fresh sequence clears the code
        lock_en = 1'b0;
        send_entry(7'h30, 16'hAAAA, 16'h5555, 1, 1, 1, 1, 1, 2'd2);
        cfg_valid = 1'b0;
        wait_idle(1000);
        chk("t4_err_code_held", 32'(err_code), 32'd2);
        lock_en = 1'b1;
        send_entry(7'h31, 16'h00F0, 16'h0F0F, 1, 1, 1, 1, 0, 2'd0);
        cfg_valid = 1'b0;
        wait_idle(1000);

        // Asynchronous reset during the second write's wait
        base = wr_cnt;
        send_entry(7'h40, 16'h0001, 16'hFFFE, 0, 1, 1, 0, 0, 2'd0);
        send_entry(7'h41, 16'h8000, 16'h7FFF, 0, 1, 1, 0, 0, 2'd0);
        cfg_valid = 1'b0;
        t = 0;
        while (wr_cnt < base + 2 && t < 500) begin @(negedge clk); t++; end
        if (t >= 500) chk("t6_wait_write_timeout", 32'(t), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        repeat (3) @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;
        send_entry(7'h42, 16'h0F00, 16'h1234, 1, 1, 1, 1, 0, 2'd0);
        cfg_valid = 1'b0;
        wait_idle(1000);

        // Spurious drdy in IDLE and FETCH, entry held through LOCK_WAIT
        base_den = den_cnt;
        spur_req = 1'b1;
        repeat (4) @(posedge clk); #1 spur_req = 1'b1;
        repeat (4) @(negedge clk);
        chk("spur_idle_busy", 32'(busy), 32'd0);
        chk("spur_idle_den", 32'(den_cnt - base_den), 32'd0);
        @(posedge clk); #1;
        send_entry(7'h50, 16'hFF00, 16'h00C3, 0, 1, 1, 0, 0, 2'd0);
        cfg_valid = 1'b0;
        t = 0;
        while (!cfg_ready && t < 500) begin @(negedge clk); t++; end
        if (t >= 500) chk("t7_fetch_timeout", 32'(t), 32'd0);
        base_den = den_cnt;
        @(posedge clk); #1 spur_req = 1'b1;
        repeat (3) @(posedge clk); #1 spur_req = 1'b1;
        repeat (4) @(negedge clk);
        chk("spur_fetch_ready", 32'({busy, cfg_ready}), 32'd3);
        chk("spur_fetch_den", 32'(den_cnt - base_den), 32'd0);
        @(posedge clk); #1;
        send_entry(7'h51, 16'h0000, 16'h4321, 1, 1, 1, 1, 0, 2'd0);
        send_entry(7'h52, 16'h00FF, 16'h9900, 1, 1, 1, 1, 0, 2'd0);
        cfg_valid = 1'b0;
        wait_idle(1000);

        chk("acc_queue_empty", 32'(acc_q.size()), 32'd0);
        chk("res_queue_empty", 32'(res_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
